// File: rtl/tone_pkg.sv
// -----------------------------------------------------------------------------
// tone_pkg
// Shared constants and types for the tone generator and its neighbours
// (the key priority encoder uses MUTE_DIV as its "no key" code).
//   TONE_DIV_W / TONE_PER_W : default divider and period-counter widths
//   MUTE_DIV                : divider code meaning "no key" (all ones)
//   PER_MAX                 : saturation value of the period counter
//   tone_state_t            : FSM state encoding (ST_IDLE / ST_RUN)
// -----------------------------------------------------------------------------
package tone_pkg;

    localparam int TONE_DIV_W = 16;
    localparam int TONE_PER_W = 8;

    localparam logic [TONE_DIV_W-1:0] MUTE_DIV = {TONE_DIV_W{1'b1}};
    localparam logic [TONE_PER_W-1:0] PER_MAX  = {TONE_PER_W{1'b1}};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tone_state_t;

endpackage

// File: rtl/tone_gen.sv
// -----------------------------------------------------------------------------
// tone_gen
// Square-wave tone generator. Half-period = div+1 clock cycles. A new divider
// is only taken at a half-period boundary, so pitch changes never glitch.
// div == all-ones or en == 0 mutes the output at the next boundary.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   div          in   [DIV_W] half-period divider, all-ones = mute
//   en           in   global sound enable, 0 behaves as mute
//   wave         out  square-wave audio output
//   active       out  1 while the FSM is in RUN
//   note_start   out  one-cycle pulse whenever a new divider is latched
//   note_periods out  [PER_W] full periods of the current note, saturating
// -----------------------------------------------------------------------------
module tone_gen
    import tone_pkg::*;
#(
    parameter int DIV_W = TONE_DIV_W,
    parameter int PER_W = TONE_PER_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] div,
    input  logic             en,
    output logic             wave,
    output logic             active,
    output logic             note_start,
    output logic [PER_W-1:0] note_periods
);

    localparam logic [DIV_W-1:0] W_MUTE_DIV = {DIV_W{1'b1}};
    localparam logic [PER_W-1:0] W_PER_MAX  = {PER_W{1'b1}};

    tone_state_t      r_state, w_state_next;
    logic [DIV_W-1:0] r_cur_div, w_cur_div_next;
    logic [DIV_W-1:0] r_cnt, w_cnt_next;
    logic             r_wave, w_wave_next;
    logic [PER_W-1:0] r_periods, w_periods_next;
    logic             r_note_start, w_note_start_next;

    logic w_mute;
    logic w_boundary;

    assign w_mute     = (!en) || (div == W_MUTE_DIV);
    assign w_boundary = (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cur_div    <= '0;
            r_cnt        <= '0;
            r_wave       <= 1'b0;
            r_periods    <= '0;
            r_note_start <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cur_div    <= w_cur_div_next;
            r_cnt        <= w_cnt_next;
            r_wave       <= w_wave_next;
            r_periods    <= w_periods_next;
            r_note_start <= w_note_start_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_cur_div_next    = r_cur_div;
        w_cnt_next        = r_cnt;
        w_wave_next       = r_wave;
        w_periods_next    = r_periods;
        w_note_start_next = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_wave_next    = 1'b0;
                w_periods_next = '0;
                if (!w_mute) begin
                    w_cur_div_next    = div;
                    w_cnt_next        = div;
                    w_wave_next       = 1'b1;
                    w_state_next      = ST_RUN;
                    w_note_start_next = 1'b1;
                end
            end

            ST_RUN: begin
                if (!w_boundary) begin
                    // Mid half-period: only the counter moves; div/en ignored.
                    w_cnt_next = r_cnt - 1'b1;
                end else if (w_mute) begin
                    // Mute wins over a simultaneous pitch change.
                    w_wave_next    = 1'b0;
                    w_state_next   = ST_IDLE;
                    w_periods_next = '0;
                    w_cnt_next     = '0;
                end else if (div != r_cur_div) begin
                    w_cur_div_next    = div;
                    w_cnt_next        = div;
                    w_wave_next       = ~r_wave;
                    w_note_start_next = 1'b1;
                    w_periods_next    = '0;
                end else begin
                    w_cnt_next  = r_cur_div;
                    w_wave_next = ~r_wave;
                    // A low->high edge marks completion of a full period.
                    if (!r_wave && (r_periods != W_PER_MAX)) begin
                        w_periods_next = r_periods + 1'b1;
                    end
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign wave         = r_wave;
    assign active       = (r_state == ST_RUN);
    assign note_start   = r_note_start;
    assign note_periods = r_periods;

endmodule

// File: tb/tb_tone_gen.sv
// -----------------------------------------------------------------------------
// tb_tone_gen
// Scoreboard bench for tone_gen. The stimulus process drives one input vector
// per clock and pushes the output state expected after that edge; a monitor
// pops and compares on every falling edge.
// -----------------------------------------------------------------------------
module tb_tone_gen;

    localparam int DIV_W = 16;
    localparam int PER_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [DIV_W-1:0] div;
    logic             en;
    logic             wave;
    logic             active;
    logic             note_start;
    logic [PER_W-1:0] note_periods;

    always #5 clk = ~clk;

    tone_gen #(
        .DIV_W(DIV_W),
        .PER_W(PER_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .div         (div),
        .en          (en),
        .wave        (wave),
        .active      (active),
        .note_start  (note_start),
        .note_periods(note_periods)
    );

    typedef struct packed {
        int         tid;
        int         cyc;
        logic       w;
        logic       a;
        logic       ns;
        logic [7:0] np;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Monitor: one expectation per clock, sampled mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_vec = n_vec + 1;
            if ({wave, active, note_start, note_periods} !== {e.w, e.a, e.ns, e.np}) begin
                n_miss = n_miss + 1;
                $display("FAIL test%0d cyc%0d: got wave=%b active=%b note_start=%b periods=%0d, exp wave=%b active=%b note_start=%b periods=%0d",
                         e.tid, e.cyc, wave, active, note_start, note_periods,
                         e.w, e.a, e.ns, e.np);
            end else begin
                $display("ok   test%0d cyc%0d: wave=%b active=%b note_start=%b periods=%0d",
                         e.tid, e.cyc, wave, active, note_start, note_periods);
            end
        end
    end

    // Drive one vector, record the outputs expected after the next edge.
    task automatic step(input int tid, input int cyc,
                        input logic r, input logic e_in, input logic [DIV_W-1:0] d,
                        input logic ew, input logic ea, input logic ens, input int enp);
        exp_t x;
        rst = r;
        en  = e_in;
        div = d;
        x.tid = tid;
        x.cyc = cyc;
        x.w   = ew;
        x.a   = ea;
        x.ns  = ens;
        x.np  = enp[7:0];
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int tid);
        for (int i = 0; i < 2; i++) step(tid, i - 2, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        div = '0;

        // 1: basic tone, div=3 -> 1111 0000, periods count at each rising edge.
        do_reset(1);
        for (int k = 0; k < 32; k++)
            step(1, k, 1'b0, 1'b1, 16'd3, ((k % 8) < 4), 1'b1, (k == 0), k / 8);

        // 2: pitch change two cycles into a high phase; old phase completes.
        do_reset(2);
        for (int k = 0; k < 22; k++) begin
            if (k < 12) begin
                step(2, k, 1'b0, 1'b1, (k < 10) ? 16'd3 : 16'd1,
                     ((k % 8) < 4), 1'b1, (k == 0), k / 8);
            end else begin
                int j;
                j = k - 12;
                step(2, k, 1'b0, 1'b1, 16'd1, ((j % 4) >= 2), 1'b1, (j == 0), (j + 2) / 4);
            end
        end

        // 3: mute mid high phase; the 6-cycle high phase still completes.
        do_reset(3);
        for (int k = 0; k < 26; k++) begin
            if (k < 18)
                step(3, k, 1'b0, 1'b1, (k < 14) ? 16'd5 : 16'hFFFF,
                     ((k % 12) < 6), 1'b1, (k == 0), k / 12);
            else
                step(3, k, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 0);
        end

        // 4: en dropped with a div change on a boundary -> mute, no note_start.
        for (int k = 0; k < 6; k++)
            step(4, k, 1'b0, 1'b1, 16'd2, ((k % 6) < 3), 1'b1, (k == 0), 0);
        step(4, 6, 1'b0, 1'b0, 16'd7, 1'b0, 1'b0, 1'b0, 0);
        step(4, 7, 1'b0, 1'b0, 16'd7, 1'b0, 1'b0, 1'b0, 0);
        // Restart, then reset mid high phase, then clean restart.
        for (int k = 0; k < 3; k++)
            step(4, 8 + k, 1'b0, 1'b1, 16'd7, 1'b1, 1'b1, (k == 0), 0);
        step(4, 11, 1'b1, 1'b1, 16'd7, 1'b0, 1'b0, 1'b0, 0);
        for (int j = 0; j < 20; j++)
            step(4, 12 + j, 1'b0, 1'b1, 16'd7, ((j % 16) < 8), 1'b1, (j == 0), j / 16);

        // 5: div=0 for 600 cycles: toggle every cycle, periods saturate at 255.
        do_reset(5);
        for (int k = 0; k < 600; k++)
            step(5, k, 1'b0, 1'b1, 16'd0, ((k % 2) == 0), 1'b1, (k == 0),
                 ((k / 2) > 255) ? 255 : (k / 2));

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_miss = n_miss + 1;
            $display("FAIL drain: got %0d pending expectations, exp 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
